rpn_evaluator: RTL and testbench
================================

RPN_EVALUATOR -- requirements
Module: rpn_evaluator

Interface
REQ-001 SHALL have parameter INTEGER_PART_WIDTH, default 8, integer bits of Q-format values.
REQ-002 SHALL have parameter FRACTIONAL_PART_WIDTH, default 8, fraction bits; N = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH.
REQ-003 SHALL have parameter OUTPUT_QUEUE_SIZE, default 64, number of RPN queue entries.
REQ-004 SHALL have parameter STACK_SIZE, default 16, depth of the internal value stack.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port start, input, 1, begin evaluation; sampled only in IDLE.
REQ-008 SHALL have port x, input, N, signed Q value substituted for VAR; latched at start.
REQ-009 SHALL have port queue_length, input, clog2(OUTPUT_QUEUE_SIZE)+1, entries written by the parser; latched at start.
REQ-010 SHALL have port queue_index, output, clog2(OUTPUT_QUEUE_SIZE), read address into the RPN queue.
REQ-011 SHALL have port queue_data, input, N+1, entry at queue_index one cycle after the address is presented; bit N=1 marks an operator code in bits [2:0] (0 PLUS, 1 SUB, 2 MUL, 3 DIV, 4 POW, 6 VAR); bit N=0 marks an unsigned Q operand.
REQ-012 SHALL have port ready, output, 1, high only in IDLE.
REQ-013 SHALL have port result, output, N, signed Q result; held until the next start.
REQ-014 SHALL have port result_valid, output, 1, one-cycle pulse on completion.
REQ-015 SHALL have port error, output, 1, valid with result_valid, held until the next start.

Function
REQ-016 SHALL use states IDLE, FETCH, WAIT, DECODE, DIV_LOOP, POW_LOOP, FINISH.
REQ-017 IDLE with start=1 SHALL latch x and queue_length, clear queue_index, stack pointer, error and result, then go to FETCH; start while not in IDLE SHALL be ignored.
REQ-018 FETCH SHALL go to FINISH if queue_index == latched length, else to WAIT; WAIT SHALL go to DECODE one cycle later (one-cycle read latency).
REQ-019 DECODE on an operand SHALL push it zero-extended as positive Q value; on VAR SHALL push latched x; then increment queue_index and return to FETCH.
REQ-020 PLUS/SUB SHALL pop b then a and push a+b / a-b, modulo 2^N, in one DECODE cycle.
REQ-021 MUL SHALL push the signed 2N-bit product arithmetic-shifted right by FRACTIONAL_PART_WIDTH, truncated to N bits.
REQ-022 DIV SHALL enter DIV_LOOP, compute (|a| << FRACTIONAL_PART_WIDTH) / |b| by restoring division, one quotient bit per cycle for N+FRACTIONAL_PART_WIDTH cycles, negate if signs differ, truncate to N bits, push, return to FETCH.
REQ-023 Division with b == 0 SHALL set error and go to FINISH without entering DIV_LOOP.
REQ-024 A binary operator with fewer than 2 stack entries (underflow) SHALL set error and go to FINISH.
REQ-025 A push with STACK_SIZE entries already stored (overflow) SHALL set error and go to FINISH.
REQ-026 An operator code of 5 or 7 SHALL set error and go to FINISH.
REQ-027 FINISH SHALL set result to the top of stack and error=0 if exactly one entry remains and no error occurred; otherwise result=0 and error=1; pulse result_valid and go to IDLE.
REQ-028 An empty queue (length 0) SHALL produce error=1, result=0.

Reset
REQ-029 rst=1 SHALL, at the next edge and from any state including mid-DIV_LOOP/POW_LOOP, force IDLE, queue_index=0, stack pointer=0, result=0, result_valid=0, error=0.
REQ-030 rst SHALL take priority over start in the same cycle.

Configuration
REQ-031 With macro RPN_EVALUATOR_POW_EN defined, POW SHALL pop b then a, take integer part e of b; if b is negative or e > 15 set error, else enter POW_LOOP computing a^e by e sequential MUL steps (a^0 = 1.0), push, return to FETCH.
REQ-032 With RPN_EVALUATOR_POW_EN undefined, POW SHALL set error and go to FINISH, and no POW_LOOP logic SHALL be synthesized.

Verification
REQ-033 Queue [0x00200, 0x00300, PLUS] (2, 3, +), x=0 -> result=0x0500, error=0, one result_valid pulse.
REQ-034 Queue [VAR, VAR, MUL], x=0x0180 (1.5) -> result=0x0240 (2.25), error=0.
REQ-035 Queue [7.0, 2.0, DIV] -> result=0x0380 (3.5) after the 24-cycle DIV_LOOP; [1.0, 0, DIV] -> error=1, result=0.
REQ-036 Queue [PLUS] -> underflow, error=1; queue [1.0, 2.0] -> two entries left, error=1.
REQ-037 Queue [2.0, 3.0, POW] -> 0x0800 with RPN_EVALUATOR_POW_EN, error=1 without.
REQ-038 rst asserted during DIV_LOOP -> next cycle ready=1, result=0, no result_valid pulse; subsequent start evaluates normally.

Source files
------------

// File: rtl/rpn_evaluator.sv
// Fixed-point RPN evaluator: walks a parser-filled queue and reduces it on an internal value stack.
// Latency: 3 cycles per token, plus N+FRACTIONAL_PART_WIDTH cycles per DIV and up to 16 per POW, plus 2 to finish.
// Backpressure: none; start is honoured only while ready (IDLE), and result/error hold until the next start.
// Optional POW operator: define RPN_EVALUATOR_POW_EN to build the POW_LOOP datapath.
module rpn_evaluator #(
  parameter int INTEGER_PART_WIDTH    = 8,
  parameter int FRACTIONAL_PART_WIDTH = 8,
  parameter int OUTPUT_QUEUE_SIZE     = 64,
  parameter int STACK_SIZE            = 16,
  localparam int N  = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH,
  localparam int QW = $clog2(OUTPUT_QUEUE_SIZE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  x,
  input  logic [QW:0]   queue_length,
  output logic [QW-1:0] queue_index,
  input  logic [N:0]    queue_data,
  output logic          ready,
  output logic [N-1:0]  result,
  output logic          result_valid,
  output logic          error
);

  localparam int FW  = FRACTIONAL_PART_WIDTH;
  localparam int SAW = $clog2(STACK_SIZE);
  localparam int SPW = SAW + 1;
  localparam int DW  = N + FW;
  localparam int DCW = $clog2(DW + 1);

  localparam logic [SPW-1:0] SP_ONE     = SPW'(1);
  localparam logic [SPW-1:0] SP_TWO     = SPW'(2);
  localparam logic [SPW-1:0] SP_FULL    = SPW'(STACK_SIZE);
  localparam logic [QW:0]    RD_ONE     = (QW+1)'(1);
  localparam logic [DCW-1:0] DIV_CYCLES = DCW'(DW);
  localparam logic [DCW-1:0] DC_ONE     = DCW'(1);

  localparam logic [2:0] OP_PLUS = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MUL  = 3'd2;
  localparam logic [2:0] OP_DIV  = 3'd3;
  localparam logic [2:0] OP_POW  = 3'd4;
  localparam logic [2:0] OP_VAR  = 3'd6;

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT, DECODE, DIV_LOOP,
`ifdef RPN_EVALUATOR_POW_EN
    POW_LOOP,
`endif
    FINISH
  } state_t;

  state_t          state, state_next;
  logic [N-1:0]    stack [STACK_SIZE];
  logic [SPW-1:0]  sp, sp_m1;
  logic [SAW-1:0]  sp_m2;
  logic [QW:0]     rd_ptr, len_lat;
  logic [N-1:0]    x_lat;
  logic [N-1:0]    opa, opb, abs_a, abs_b;
  logic            is_op, set_err;
  logic [2:0]      opc;

  // Restoring divider state: dq shifts the dividend out and the quotient in.
  logic [N-1:0]    div_rem, div_dvs, rem_nxt, quot;
  logic [DW-1:0]   div_dq, dq_nxt;
  logic [N:0]      rem_sh;
  logic            div_neg;
  logic [DCW-1:0]  div_cnt;

`ifdef RPN_EVALUATOR_POW_EN
  localparam logic [INTEGER_PART_WIDTH-1:0] POW_MAX = INTEGER_PART_WIDTH'(15);
  localparam logic [N-1:0] ONE_Q = N'(1 << FW);
  logic [N-1:0]    pow_acc, pow_base;
  logic [3:0]      pow_cnt;
`endif

  // Q-format multiply: full signed product, rescaled by the fraction width.
  function automatic logic [N-1:0] fx_mul(input logic [N-1:0] a, input logic [N-1:0] b);
    logic signed [2*N-1:0] p;
    p = $signed(a) * $signed(b);
    return N'(p >>> FW);
  endfunction

  assign queue_index = rd_ptr[QW-1:0];
  assign ready       = (state == IDLE);
  assign is_op       = queue_data[N];
  assign opc         = queue_data[2:0];
  assign sp_m1       = sp - SP_ONE;
  assign sp_m2       = SAW'(sp - SP_TWO);
  assign opb         = stack[sp_m1[SAW-1:0]];
  assign opa         = stack[sp_m2];
  assign abs_a       = opa[N-1] ? -opa : opa;
  assign abs_b       = opb[N-1] ? -opb : opb;

  // One restoring-division step and the signed, truncated quotient it would yield.
  always_comb begin
    rem_sh = {div_rem, div_dq[DW-1]};
    if (rem_sh >= {1'b0, div_dvs}) begin
      rem_nxt = N'(rem_sh - {1'b0, div_dvs});
      dq_nxt  = {div_dq[DW-2:0], 1'b1};
    end else begin
      rem_nxt = rem_sh[N-1:0];
      dq_nxt  = {div_dq[DW-2:0], 1'b0};
    end
    quot = div_neg ? -dq_nxt[N-1:0] : dq_nxt[N-1:0];
  end

  // State register; reset wins over everything, including start.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic, including every error exit to FINISH.
  always_comb begin
    state_next = state;
    set_err    = 1'b0;
    case (state)
      IDLE:     if (start) state_next = FETCH;
      FETCH:    state_next = (rd_ptr == len_lat) ? FINISH : WAIT;
      WAIT:     state_next = DECODE;
      DECODE: begin
        state_next = FETCH;
        if (!is_op) begin
          set_err = (sp == SP_FULL);
        end else begin
          case (opc)
            OP_PLUS, OP_SUB, OP_MUL: set_err = (sp < SP_TWO);
            OP_DIV: begin
              set_err = (sp < SP_TWO) || (opb == '0);
              state_next = DIV_LOOP;
            end
`ifdef RPN_EVALUATOR_POW_EN
            OP_POW: begin
              set_err = (sp < SP_TWO) || opb[N-1] || (opb[N-1:FW] > POW_MAX);
              state_next = POW_LOOP;
            end
`endif
            OP_VAR:  set_err = (sp == SP_FULL);
            default: set_err = 1'b1;
          endcase
        end
        if (set_err) state_next = FINISH;
      end
      DIV_LOOP: if (div_cnt == DC_ONE) state_next = FETCH;
`ifdef RPN_EVALUATOR_POW_EN
      POW_LOOP: if (pow_cnt == '0) state_next = FETCH;
`endif
      FINISH:   state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Datapath: stack, read pointer, iterative units and the result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr       <= '0;
      sp           <= '0;
      len_lat      <= '0;
      x_lat        <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      error        <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: if (start) begin
          x_lat   <= x;
          len_lat <= queue_length;
          rd_ptr  <= '0;
          sp      <= '0;
          error   <= 1'b0;
          result  <= '0;
        end
        DECODE: begin
          if (set_err) begin
            error <= 1'b1;
          end else if (!is_op) begin
            stack[sp[SAW-1:0]] <= queue_data[N-1:0];
            sp     <= sp + SP_ONE;
            rd_ptr <= rd_ptr + RD_ONE;
          end else begin
            case (opc)
              OP_PLUS, OP_SUB, OP_MUL: begin
                stack[sp_m2] <= (opc == OP_PLUS) ? opa + opb :
                                (opc == OP_SUB)  ? opa - opb : fx_mul(opa, opb);
                sp     <= sp_m1;
                rd_ptr <= rd_ptr + RD_ONE;
              end
              OP_DIV: begin
                div_rem <= '0;
                div_dq  <= {abs_a, {FW{1'b0}}};
                div_dvs <= abs_b;
                div_neg <= opa[N-1] ^ opb[N-1];
                div_cnt <= DIV_CYCLES;
              end
`ifdef RPN_EVALUATOR_POW_EN
              OP_POW: begin
                pow_acc  <= ONE_Q;
                pow_base <= opa;
                pow_cnt  <= opb[FW+3:FW];
              end
`endif
              OP_VAR: begin
                stack[sp[SAW-1:0]] <= x_lat;
                sp     <= sp + SP_ONE;
                rd_ptr <= rd_ptr + RD_ONE;
              end
              default: ;
            endcase
          end
        end
        DIV_LOOP: begin
          div_rem <= rem_nxt;
          div_dq  <= dq_nxt;
          div_cnt <= div_cnt - DC_ONE;
          if (div_cnt == DC_ONE) begin
            stack[sp_m2] <= quot;
            sp     <= sp_m1;
            rd_ptr <= rd_ptr + RD_ONE;
          end
        end
`ifdef RPN_EVALUATOR_POW_EN
        POW_LOOP: begin
          if (pow_cnt == '0) begin
            stack[sp_m2] <= pow_acc;
            sp     <= sp_m1;
            rd_ptr <= rd_ptr + RD_ONE;
          end else begin
            pow_acc <= fx_mul(pow_acc, pow_base);
            pow_cnt <= pow_cnt - 4'd1;
          end
        end
`endif
        FINISH: begin
          result_valid <= 1'b1;
          if (!error && sp == SP_ONE) begin
            result <= stack[0];
          end else begin
            result <= '0;
            error  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rpn_evaluator.sv
// Bench for rpn_evaluator: directed cases plus random RPN programs against a queue-based model.
// Latency: each program is awaited for at most a fixed number of cycles.
// Backpressure: none; the queue memory answers one cycle after the address.
module tb_rpn_evaluator;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [15:0] x;
  logic [6:0]  queue_length;
  logic [5:0]  queue_index;
  logic [16:0] queue_data;
  logic        ready;
  logic [15:0] result;
  logic        result_valid, error;

  logic [16:0] mem [64];
  int checks   = 0;
  int failures = 0;

  localparam logic [16:0] T_PLUS = 17'h10000;
  localparam logic [16:0] T_SUB  = 17'h10001;
  localparam logic [16:0] T_MUL  = 17'h10002;
  localparam logic [16:0] T_DIV  = 17'h10003;
  localparam logic [16:0] T_POW  = 17'h10004;
  localparam logic [16:0] T_VAR  = 17'h10006;

  rpn_evaluator dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .queue_length(queue_length),
    .queue_index(queue_index), .queue_data(queue_data), .ready(ready),
    .result(result), .result_valid(result_valid), .error(error)
  );

  always #5 clk = ~clk;

  // Synchronous-read queue memory.
  always @(posedge clk) queue_data <= mem[queue_index];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] num(input int v);
    return {1'b0, 16'(v)};
  endfunction

  function automatic int sx(input int v);
    return (v & 32'h8000) != 0 ? (v & 32'hFFFF) - 65536 : (v & 32'hFFFF);
  endfunction

  function automatic int qmul(input int a, input int b);
    longint p;
    p = longint'(sx(a)) * longint'(sx(b));
    p = p >>> 8;
    return int'(p & 64'hFFFF);
  endfunction

  function automatic int qdiv(input int a, input int b);
    longint na, nb, q;
    na = sx(a) < 0 ? -longint'(sx(a)) : longint'(sx(a));
    nb = sx(b) < 0 ? -longint'(sx(b)) : longint'(sx(b));
    q  = (na << 8) / nb;
    if ((sx(a) < 0) != (sx(b) < 0)) q = -q;
    return int'(q & 64'hFFFF);
  endfunction

  // Reference: evaluate the program straight from the operator rules.
  function automatic void model(input int len, input logic [15:0] xv,
                                output logic [15:0] r, output logic e);
    int st[$];
    int a, b, acc, code;
    bit bad = 0;
    logic [16:0] t;
    for (int i = 0; i < len && !bad; i++) begin
      t = mem[i];
      code = int'(t[2:0]);
      if (!t[16] || code == 6) begin
        if (st.size() >= 16) bad = 1;
        else st.push_back(t[16] ? int'(xv) : int'(t[15:0]));
      end else if (code <= 4) begin
        if (st.size() < 2) bad = 1;
        else begin
          b = st.pop_back();
          a = st.pop_back();
          case (code)
            0: st.push_back((a + b) & 32'hFFFF);
            1: st.push_back((a - b) & 32'hFFFF);
            2: st.push_back(qmul(a, b));
            3: if (b == 0) bad = 1; else st.push_back(qdiv(a, b));
            default: begin
`ifdef RPN_EVALUATOR_POW_EN
              if (sx(b) < 0 || (b >> 8) > 15) bad = 1;
              else begin
                acc = 256;
                for (int k = 0; k < (b >> 8); k++) acc = qmul(acc, a);
                st.push_back(acc);
              end
`else
              bad = 1;
`endif
            end
          endcase
        end
      end else bad = 1;
    end
    if (!bad && st.size() == 1) begin r = 16'(st[0]); e = 1'b0; end
    else begin r = 16'h0; e = 1'b1; end
  endfunction

  // Start one evaluation, wait for its pulse, compare with the model.
  task automatic run(input string tag, input int len, input logic [15:0] xv,
                     output logic [15:0] r, output logic e, output int cyc);
    logic done;
    logic [15:0] ref_r;
    logic ref_e;
    model(len, xv, ref_r, ref_e);
    x = xv;
    queue_length = 7'(len);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk({tag, " busy"}, ready, 1'b0);
    done = 1'b0; cyc = 0; r = '0; e = 1'b0;
    while (!done && cyc < 3000) begin
      if (result_valid === 1'b1) begin
        done = 1'b1; r = result; e = error;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk({tag, " done"}, done, 1'b1);
    if (done) begin
      chk({tag, " result"}, r, ref_r);
      chk({tag, " error"}, e, ref_e);
      @(negedge clk);
      chk({tag, " pulse"}, result_valid, 1'b0);
      chk({tag, " hold"}, result, r);
      chk({tag, " ready"}, ready, 1'b1);
    end
  endtask

  task automatic put(input logic [16:0] t, inout int len);
    mem[len] = t;
    len++;
  endtask

  task automatic push_rand(inout int len, inout int depth);
    int k;
    k = $urandom_range(0, 9);
    if (k <= 2)      put(T_VAR, len);
    else if (k == 3) put(num(0), len);
    else if (k == 4) put(num($urandom_range(0, 16'hFFFF)), len);
    else             put(num($urandom_range(0, 16'h0A00)), len);
    depth++;
  endtask

  task automatic add_op(inout int len, inout int depth);
    int k;
    k = $urandom_range(0, 4);
    if (k == 4) begin
      put(num($urandom_range(0, 4) << 8), len);
      put(T_POW, len);
    end else begin
      put({1'b1, 13'h0, 3'(k)}, len);
      depth--;
    end
  endtask

  task automatic gen(output int len);
    int mode, depth, n;
    mode = $urandom_range(0, 9);
    depth = 0;
    len = 0;
    if (mode == 0) begin
      n = $urandom_range(0, 12);
      for (int i = 0; i < n; i++)
        put($urandom_range(0, 1) ? {1'b1, 13'h0, 3'($urandom_range(0, 7))}
                                 : {1'b0, 16'($urandom)}, len);
    end else if (mode == 1) begin
      n = $urandom_range(15, 18);
      for (int i = 0; i < n; i++) put(num($urandom_range(0, 16'h0400)), len);
      for (int i = 1; i < n; i++) put(T_PLUS, len);
    end else begin
      n = $urandom_range(1, 10);
      for (int s = 0; s < n; s++) begin
        if (depth < 2 || $urandom_range(0, 2) == 0) push_rand(len, depth);
        else add_op(len, depth);
      end
      if (mode != 2) while (depth > 1) add_op(len, depth);
    end
  endtask

  logic [15:0] r;
  logic        e;
  int          cyc, plus_cyc, div_cyc, len, pulses, busy;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    rst = 1'b1; start = 1'b0; x = '0; queue_length = '0;
    repeat (2) @(negedge clk);
    chk("reset ready", ready, 1'b1);
    chk("reset valid", result_valid, 1'b0);
    chk("reset result", result, 16'h0);
    chk("reset error", error, 1'b0);
    chk("reset index", queue_index, 6'h0);
    rst = 1'b0;

    mem[0] = num(16'h0200); mem[1] = num(16'h0300); mem[2] = T_PLUS;
    run("add", 3, 16'h0, r, e, plus_cyc);
    chk("add value", r, 16'h0500); chk("add flag", e, 1'b0);

    mem[0] = T_VAR; mem[1] = T_VAR; mem[2] = T_MUL;
    run("mul", 3, 16'h0180, r, e, cyc);
    chk("mul value", r, 16'h0240); chk("mul flag", e, 1'b0);

    mem[0] = num(16'h0700); mem[1] = num(16'h0200); mem[2] = T_DIV;
    run("div", 3, 16'h0, r, e, div_cyc);
    chk("div value", r, 16'h0380); chk("div flag", e, 1'b0);
    chk("div loop cycles", div_cyc - plus_cyc, 24);

    mem[0] = num(16'hF900); mem[1] = num(16'h0200); mem[2] = T_DIV;
    run("negdiv", 3, 16'h0, r, e, cyc);
    chk("negdiv value", r, 16'hFC80);

    mem[0] = num(16'h0100); mem[1] = num(16'h0000); mem[2] = T_DIV;
    run("div0", 3, 16'h0, r, e, cyc);
    chk("div0 value", r, 16'h0); chk("div0 flag", e, 1'b1);

    mem[0] = T_PLUS;
    run("underflow", 1, 16'h0, r, e, cyc);
    chk("underflow flag", e, 1'b1);

    mem[0] = num(16'h0100); mem[1] = num(16'h0200);
    run("leftover", 2, 16'h0, r, e, cyc);
    chk("leftover flag", e, 1'b1);

    run("empty", 0, 16'h0, r, e, cyc);
    chk("empty value", r, 16'h0); chk("empty flag", e, 1'b1);

    len = 0;
    for (int i = 1; i <= 16; i++) put(num(i << 8), len);
    for (int i = 1; i < 16; i++) put(T_PLUS, len);
    run("fullstack", len, 16'h0, r, e, cyc);
    chk("fullstack value", r, 16'h8800); chk("fullstack flag", e, 1'b0);

    len = 0;
    for (int i = 1; i <= 17; i++) put(num(i << 8), len);
    run("overflow", len, 16'h0, r, e, cyc);
    chk("overflow flag", e, 1'b1);

    mem[0] = num(16'h0200); mem[1] = num(16'h0300); mem[2] = T_POW;
    run("pow", 3, 16'h0, r, e, cyc);
`ifdef RPN_EVALUATOR_POW_EN
    chk("pow value", r, 16'h0800); chk("pow flag", e, 1'b0);
`else
    chk("pow flag", e, 1'b1);
`endif

    // Reset in the middle of a division.
    mem[0] = num(16'h0700); mem[1] = num(16'h0200); mem[2] = T_DIV;
    x = 16'h0; queue_length = 7'd3;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (14) @(negedge clk);
    chk("middiv busy", ready, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("middiv ready", ready, 1'b1);
    chk("middiv result", result, 16'h0);
    chk("middiv valid", result_valid, 1'b0);
    chk("middiv error", error, 1'b0);
    chk("middiv index", queue_index, 6'h0);
    rst = 1'b0;
    pulses = 0; busy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (result_valid) pulses++;
      if (!ready) busy++;
    end
    chk("middiv no pulse", pulses, 0);
    chk("middiv stays idle", busy, 0);
    run("afterrst", 3, 16'h0, r, e, cyc);
    chk("afterrst value", r, 16'h0380);

    // Reset and start in the same cycle: reset wins.
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    busy = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!ready || result_valid) busy++;
    end
    chk("rst over start", busy, 0);

    for (int t = 0; t < 150; t++) begin
      gen(len);
      run($sformatf("rnd%0d", t), len, 16'($urandom), r, e, cyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
